target_generator: RTL and testbench

//  Places the snake's food target at a pseudo-random in-bounds pixel and detects when the snake head reaches it.

---
 rtl/target_if.sv | 24 ++
 rtl/target_generator.sv | 102 ++++++++++
 tb/tb_target_generator.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/target_if.sv
// Bundle between the snake datapath and the target generator: head position in,
// placed target and hit pulse out.
interface target_if #(
  parameter int X_WIDTH = 8,
  parameter int Y_WIDTH = 7
);
  logic               GAME_ACTIVE;
  logic [X_WIDTH-1:0] HEAD_X;
  logic [Y_WIDTH-1:0] HEAD_Y;
  logic [X_WIDTH-1:0] TARGET_X;
  logic [Y_WIDTH-1:0] TARGET_Y;
  logic               TARGET_VALID;
  logic               REACHED_TARGET;

  modport master (
    output GAME_ACTIVE, HEAD_X, HEAD_Y,
    input  TARGET_X, TARGET_Y, TARGET_VALID, REACHED_TARGET
  );

  modport slave (
    input  GAME_ACTIVE, HEAD_X, HEAD_Y,
    output TARGET_X, TARGET_Y, TARGET_VALID, REACHED_TARGET
  );
endinterface

// File: rtl/target_generator.sv
// Food target placement for the snake game: free-running LFSRs propose candidates,
// the first in-bounds one not under the head is latched, and a head hit pulses once.
module target_generator #(
  parameter int                 X_WIDTH = 8,
  parameter int                 Y_WIDTH = 7,
  parameter int                 X_MAX   = 159,
  parameter int                 Y_MAX   = 119,
  parameter logic [X_WIDTH-1:0] SEED_X  = 8'hA5,
  parameter logic [Y_WIDTH-1:0] SEED_Y  = 7'h3C
) (
  input  logic     CLK,
  input  logic     RESET,
  target_if.slave  bus
);

  localparam logic [X_WIDTH-1:0] X_LIM = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0] Y_LIM = Y_WIDTH'(Y_MAX);

  typedef enum logic [1:0] {IDLE, PLACE, ARMED} state_e;

  state_e             state_q, state_d;
  logic [X_WIDTH-1:0] lfsr_x_q, lfsr_x_d;
  logic [Y_WIDTH-1:0] lfsr_y_q, lfsr_y_d;
  logic [X_WIDTH-1:0] tgt_x_q, tgt_x_d;
  logic [Y_WIDTH-1:0] tgt_y_q, tgt_y_d;
  logic               valid_q, valid_d;
  logic               reached_q, reached_d;
  logic               cand_ok;
  logic               head_hit;

  // Fibonacci LFSRs: x taps 8,6,5,4 and y taps 7,6, both maximal length.
  assign lfsr_x_d = {lfsr_x_q[X_WIDTH-2:0],
                     lfsr_x_q[7] ^ lfsr_x_q[5] ^ lfsr_x_q[4] ^ lfsr_x_q[3]};
  assign lfsr_y_d = {lfsr_y_q[Y_WIDTH-2:0], lfsr_y_q[6] ^ lfsr_y_q[5]};

  assign cand_ok  = (lfsr_x_q <= X_LIM) && (lfsr_y_q <= Y_LIM) &&
                    !((lfsr_x_q == bus.HEAD_X) && (lfsr_y_q == bus.HEAD_Y));
  assign head_hit = (bus.HEAD_X == tgt_x_q) && (bus.HEAD_Y == tgt_y_q);

  always_comb begin
    state_d   = state_q;
    tgt_x_d   = tgt_x_q;
    tgt_y_d   = tgt_y_q;
    valid_d   = valid_q;
    reached_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.GAME_ACTIVE) begin
          state_d = PLACE;
          valid_d = 1'b0;
        end
      end
      PLACE: begin
        if (!bus.GAME_ACTIVE) begin
          state_d = IDLE;
        end else if (cand_ok) begin
          tgt_x_d = lfsr_x_q;
          tgt_y_d = lfsr_y_q;
          valid_d = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        // Leaving play wins over a coincident hit, so no pulse is issued then.
        if (!bus.GAME_ACTIVE) begin
          state_d = IDLE;
        end else if (head_hit) begin
          reached_d = 1'b1;
          valid_d   = 1'b0;
          state_d   = PLACE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      lfsr_x_q  <= SEED_X;
      lfsr_y_q  <= SEED_Y;
      tgt_x_q   <= '0;
      tgt_y_q   <= '0;
      valid_q   <= 1'b0;
      reached_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_x_q  <= lfsr_x_d;
      lfsr_y_q  <= lfsr_y_d;
      tgt_x_q   <= tgt_x_d;
      tgt_y_q   <= tgt_y_d;
      valid_q   <= valid_d;
      reached_q <= reached_d;
    end
  end

  assign bus.TARGET_X       = tgt_x_q;
  assign bus.TARGET_Y       = tgt_y_q;
  assign bus.TARGET_VALID   = valid_q;
  assign bus.REACHED_TARGET = reached_q;

endmodule

// File: tb/tb_target_generator.sv
// Directed bench for target_generator: placements are predicted from a bench-side
// LFSR model, queued, and compared when TARGET_VALID rises.
module tb_target_generator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  target_if #(.X_WIDTH(8), .Y_WIDTH(7)) bus ();

  target_generator #(
    .X_WIDTH(8), .Y_WIDTH(7), .X_MAX(159), .Y_MAX(119),
    .SEED_X(8'hA5), .SEED_Y(7'h3C)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    int         lat;
  } place_t;
  place_t sb[$];

  function automatic logic [7:0] adv_x(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic logic [6:0] adv_y(input logic [6:0] v);
    return {v[5:0], ^(v & 7'h60)};
  endfunction

  // Reference LFSR state, tracking the value the DUT tests on the next edge.
  logic [7:0] mlx;
  logic [6:0] mly;
  always @(posedge clk) begin
    if (rst) begin
      mlx <= 8'hA5;
      mly <= 7'h3C;
    end else begin
      mlx <= adv_x(mlx);
      mly <= adv_y(mly);
    end
  end

  // Score counter hookup: counts REACHED_TARGET pulses.
  int   score = 0;
  logic game_won;
  always @(negedge clk) begin
    if (rst) score = 0;
    else if (bus.REACHED_TARGET === 1'b1) score = score + 1;
  end
  assign game_won = (score >= 10);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic predict(input logic [7:0] hx, input logic [6:0] hy);
    place_t p;
    logic [7:0] cx;
    logic [6:0] cy;
    cx = mlx;
    cy = mly;
    p.lat = 1;
    while (!((cx <= 8'd159) && (cy <= 7'd119) && !((cx == hx) && (cy == hy)))
           && (p.lat < 2000)) begin
      cx = adv_x(cx);
      cy = adv_y(cy);
      p.lat++;
    end
    p.x = cx;
    p.y = cy;
    sb.push_back(p);
  endtask

  task automatic wait_place(input string tag, output int cnt);
    place_t p;
    p = sb.pop_front();
    cnt = 0;
    while ((bus.TARGET_VALID !== 1'b1) && (cnt < 300)) begin
      step();
      cnt++;
    end
    check({tag, "_latency"}, cnt, p.lat);
    check({tag, "_tx"}, bus.TARGET_X, p.x);
    check({tag, "_ty"}, bus.TARGET_Y, p.y);
    check({tag, "_x_range"}, (bus.TARGET_X <= 8'd159), 1);
    check({tag, "_y_range"}, (bus.TARGET_Y <= 7'd119), 1);
  endtask

  task automatic do_hit(input logic [7:0] rx, input logic [6:0] ry);
    int cnt;
    check("pre_hit_no_pulse", bus.REACHED_TARGET, 0);
    bus.HEAD_X = bus.TARGET_X;
    bus.HEAD_Y = bus.TARGET_Y;
    step();
    check("hit_pulse", bus.REACHED_TARGET, 1);
    check("hit_valid_clear", bus.TARGET_VALID, 0);
    bus.HEAD_X = rx;
    bus.HEAD_Y = ry;
    predict(rx, ry);
    wait_place("replace", cnt);
    check("pulse_one_cycle", bus.REACHED_TARGET, 0);
  endtask

  initial begin
    int cnt;
    int p0;
    int stray;
    logic [7:0] tx;
    logic [6:0] ty;

    rst = 1'b1;
    bus.GAME_ACTIVE = 1'b0;
    bus.HEAD_X = 8'd200;
    bus.HEAD_Y = 7'd127;
    step();
    step();
    rst = 1'b0;
    check("rst_tx", bus.TARGET_X, 0);
    check("rst_ty", bus.TARGET_Y, 0);
    check("rst_valid", bus.TARGET_VALID, 0);
    check("rst_reached", bus.REACHED_TARGET, 0);

    // Idle for 50 cycles: nothing may be placed or pulsed.
    stray = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.TARGET_VALID !== 1'b0 || bus.REACHED_TARGET !== 1'b0) stray++;
    end
    check("idle_quiet", stray, 0);
    check("idle_tx", bus.TARGET_X, 0);
    check("idle_ty", bus.TARGET_Y, 0);

    // First placement with an out-of-range head.
    bus.GAME_ACTIVE = 1'b1;
    step();
    check("enter_place_valid", bus.TARGET_VALID, 0);
    predict(8'd200, 7'd127);
    wait_place("first", cnt);
    check("first_within_64", (cnt <= 64), 1);

    // 1000 hit/re-place rounds.
    for (int i = 0; i < 1000; i++) do_hit(8'd200, 7'd127);

    // Head held on the target for 20 cycles: one pulse, new target elsewhere.
    tx = bus.TARGET_X;
    ty = bus.TARGET_Y;
    p0 = score;
    bus.HEAD_X = tx;
    bus.HEAD_Y = ty;
    step();
    check("hold_hit_pulse", bus.REACHED_TARGET, 1);
    predict(tx, ty);
    wait_place("hold", cnt);
    for (int i = cnt + 1; i < 20; i++) step();
    check("hold_single_pulse", score - p0, 1);
    check("hold_new_differs", ((bus.TARGET_X != tx) || (bus.TARGET_Y != ty)), 1);
    check("hold_valid", bus.TARGET_VALID, 1);

    // Hit on the same cycle GAME_ACTIVE falls: no pulse, target retained.
    tx = bus.TARGET_X;
    ty = bus.TARGET_Y;
    p0 = score;
    bus.HEAD_X = tx;
    bus.HEAD_Y = ty;
    bus.GAME_ACTIVE = 1'b0;
    step();
    check("drop_no_pulse", bus.REACHED_TARGET, 0);
    check("drop_valid_kept", bus.TARGET_VALID, 1);
    for (int i = 0; i < 3; i++) step();
    check("drop_idle_no_pulse", score - p0, 0);
    check("drop_tx", bus.TARGET_X, tx);
    check("drop_ty", bus.TARGET_Y, ty);
    bus.GAME_ACTIVE = 1'b1;
    bus.HEAD_X = 8'd200;
    bus.HEAD_Y = 7'd127;
    step();
    check("resume_valid_clear", bus.TARGET_VALID, 0);
    predict(8'd200, 7'd127);
    wait_place("resume", cnt);

    // Reset mid-ARMED, with a coincident head match.
    bus.HEAD_X = bus.TARGET_X;
    bus.HEAD_Y = bus.TARGET_Y;
    rst = 1'b1;
    step();
    check("rst_armed_tx", bus.TARGET_X, 0);
    check("rst_armed_ty", bus.TARGET_Y, 0);
    check("rst_armed_valid", bus.TARGET_VALID, 0);
    check("rst_armed_reached", bus.REACHED_TARGET, 0);
    rst = 1'b0;
    bus.HEAD_X = 8'd200;
    bus.HEAD_Y = 7'd127;
    step();
    check("rst_place_entry_valid", bus.TARGET_VALID, 0);

    // Reset mid-PLACE.
    rst = 1'b1;
    step();
    check("rst_place_tx", bus.TARGET_X, 0);
    check("rst_place_ty", bus.TARGET_Y, 0);
    check("rst_place_valid", bus.TARGET_VALID, 0);
    check("rst_place_reached", bus.REACHED_TARGET, 0);
    rst = 1'b0;
    step();
    predict(8'd200, 7'd127);
    wait_place("after_reset", cnt);

    // Ten hits into the score counter win the game.
    check("score_cleared", score, 0);
    for (int i = 0; i < 10; i++) do_hit(8'd200, 7'd127);
    check("score_ten", score, 10);
    check("game_won", game_won, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
